// File: rtl/mips_pkg.sv
// Shared widths and fetch FSM state encoding for the instruction-fetch front end.
package mips_pkg;

    localparam int OP_W    = 6;
    localparam int FUNC_W  = 6;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int FETCH_W = PC_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode port, redirect input and perf counters.
interface instr_fetch_unit_if;
    import mips_pkg::*;

    logic                 imem_req;
    logic [PC_W-1:0]      imem_addr;
    logic                 imem_ack;
    logic [INSTR_W-1:0]   imem_rdata;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic [OP_W-1:0]      op;
    logic [FUNC_W-1:0]    func;
    logic [PC_W-1:0]      instr_pc;

    logic                 branch_taken;
    logic [PC_W-1:0]      branch_target;

    logic [31:0]          fetch_count;
    logic [31:0]          stall_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, op, func, instr_pc,
        input  instr_ready,
        input  branch_taken, branch_target,
        output fetch_count, stall_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, op, func, instr_pc,
        output instr_ready,
        output branch_taken, branch_target,
        input  fetch_count, stall_count
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {pc, word} pairs; flush beats push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem requests, buffers words.
// Build option: define INSTR_FETCH_PERF_CNT_EN to include the fetch/stall performance counters.
//
//   state | meaning
//   IDLE  | first cycle after reset, no request
//   REQ   | fetching at pc while the FIFO has room for the return
//   DRAIN | redirect hit an outstanding request; wait for its ack and discard it
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    r_drain_addr;
    logic [PC_W-1:0]    w_drain_addr_nxt;
    logic [PC_W-1:0]    w_addr;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_valid;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [FETCH_W-1:0] w_fifo_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_drain_addr_nxt = r_drain_addr;
        w_req            = 1'b0;
        w_addr           = r_pc;
        w_push           = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                // Only ask when the returning word is guaranteed a slot.
                w_req = (w_fifo_count < CNT_W'(BUF_DEPTH));
                if (bus.branch_taken) begin
                    if (w_req && !bus.imem_ack) begin
                        w_state_nxt      = DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (w_req && bus.imem_ack) begin
                    w_push = 1'b1;
                end
            end
            DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (bus.imem_ack) w_state_nxt = REQ;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (bus.branch_taken)  w_pc_nxt = word_align(bus.branch_target);
        else if (w_push)       w_pc_nxt = r_pc + PC_W'(4);
        else                   w_pc_nxt = r_pc;
    end

    assign w_valid = (w_fifo_count != '0);
    assign w_flush = bus.branch_taken;
    assign w_pop   = w_valid && bus.instr_ready && !bus.branch_taken;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FETCH_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({r_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count)
    );

    logic [INSTR_W-1:0] w_instr;
    assign w_instr = w_valid ? w_fifo_rdata[INSTR_W-1:0] : '0;

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_instr;
    assign bus.op          = w_instr[INSTR_W-1 -: OP_W];
    assign bus.func        = w_instr[FUNC_W-1:0];
    assign bus.instr_pc    = w_valid ? w_fifo_rdata[FETCH_W-1:INSTR_W] : '0;

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_pop)                        r_fetch_count <= r_fetch_count + 32'd1;
            if (w_valid && !bus.instr_ready)  r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
    assign bus.stall_count = r_stall_count;
`else
    assign bus.fetch_count = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, hand-written corner sequences, randomized model run.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int BUF_DEPTH = 2;
`ifdef INSTR_FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_drain_addr;
    logic        m_drain;
    logic        m_idle;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic r, input logic b, input logic [31:0] t);
        @(negedge clk);
        bus.imem_ack      = a;
        bus.instr_ready   = r;
        bus.branch_taken  = b;
        bus.branch_target = t;
        bus.imem_rdata    = memfn(bus.imem_addr);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        logic [31:0] w;
        w = memfn(pc);
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, ".ipc"},   bus.instr_pc, pc);
        chk({tag, ".instr"}, bus.instr, w);
        chk({tag, ".op"},    32'(bus.op), 32'(w[31:26]));
        chk({tag, ".func"},  32'(bus.func), 32'(w[5:0]));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  32'(bus.imem_req), 32'(req));
        chk({tag, ".addr"}, bus.imem_addr, addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        q.delete();
        m_pc = 32'h0; m_drain = 1'b0; m_drain_addr = 32'h0; m_idle = 1'b1;
        m_fetch = 32'h0; m_stall = 32'h0;
    endtask

    // One randomized cycle checked against the transaction-level model, then the model advances.
    task automatic model_cycle(input logic a, input logic r, input logic b, input logic [31:0] t);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        ack_eff;
        logic [31:0] hw;
        drive(a, r, b, t);
        exp_valid = (q.size() != 0);
        if (m_idle) begin
            exp_req = 1'b0; exp_addr = m_pc;
        end else if (m_drain) begin
            exp_req = 1'b1; exp_addr = m_drain_addr;
        end else begin
            exp_req = (q.size() < BUF_DEPTH); exp_addr = m_pc;
        end
        chk("rnd.req",   32'(bus.imem_req), 32'(exp_req));
        chk("rnd.addr",  bus.imem_addr, exp_addr);
        chk("rnd.valid", 32'(bus.instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            hw = q[0].w;
            chk("rnd.ipc",   bus.instr_pc, q[0].pc);
            chk("rnd.instr", bus.instr, hw);
            chk("rnd.op",    32'(bus.op), 32'(hw[31:26]));
            chk("rnd.func",  32'(bus.func), 32'(hw[5:0]));
        end
        chk("rnd.fetch_count", bus.fetch_count, PERF ? m_fetch : 32'h0);
        chk("rnd.stall_count", bus.stall_count, PERF ? m_stall : 32'h0);

        ack_eff = exp_req && a;
        if (exp_valid && !r) m_stall = m_stall + 32'd1;
        if (b) begin
            if (m_drain) begin
                if (ack_eff) m_drain = 1'b0;
            end else if (exp_req && !ack_eff) begin
                m_drain = 1'b1;
                m_drain_addr = m_pc;
            end
            q.delete();
            m_pc = t & ~32'h3;
        end else begin
            if (exp_valid && r) begin
                void'(q.pop_front());
                m_fetch = m_fetch + 32'd1;
            end
            if (ack_eff) begin
                if (m_drain) m_drain = 1'b0;
                else begin
                    q.push_back('{m_pc, memfn(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_idle = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        logic [31:0] tgt;
        total = 0;
        bad   = 0;
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        vt[6] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vt[7] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
        vt[8] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC};
        vt[9] = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'hC};

        // Reset state, with a redirect held during reset that must be ignored.
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0500;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_req("rst", 1'b0, 32'h0);
        chk("rst.valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.instr", bus.instr, 32'h0);
        chk("rst.ipc",   bus.instr_pc, 32'h0);
        chk("rst.fetch_count", bus.fetch_count, 32'h0);
        chk("rst.stall_count", bus.stall_count, 32'h0);
        bus.branch_taken = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;

        // Streaming and back-pressure table.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].ack, vt[i].ready, 1'b0, 32'h0);
            chk_req($sformatf("tbl%0d", i), vt[i].req, vt[i].addr);
            chk($sformatf("tbl%0d.valid", i), 32'(bus.instr_valid), 32'(vt[i].valid));
            if (vt[i].valid) chk_head($sformatf("tbl%0d", i), vt[i].ipc);
        end
        chk("tbl.fetch_count", bus.fetch_count, PERF ? 32'd3 : 32'd0);
        chk("tbl.stall_count", bus.stall_count, PERF ? 32'd4 : 32'd0);

        // Slow memory: request and address held while waiting.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0); chk_req("lat0", 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0); chk_req("lat1", 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0); chk_req("lat2", 1'b1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0); chk_req("lat3", 1'b1, 32'h0);
        chk("lat3.valid", 32'(bus.instr_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0); chk_head("lat4", 32'h0); chk_req("lat4", 1'b1, 32'h4);

        // Redirect while a request is outstanding.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h103); chk_req("drn1", 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);   chk_req("drn2", 1'b1, 32'h0);
        chk("drn2.valid", 32'(bus.instr_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);   chk_req("drn3", 1'b1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);   chk_req("drn4", 1'b1, 32'h100);
        chk("drn4.valid", 32'(bus.instr_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);   chk_head("drn5", 32'h100);

        // Redirect coincides with ack and pop.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);  chk_req("co1", 1'b1, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h40); chk_head("co2", 32'h0); chk_req("co2", 1'b1, 32'h4);
        drive(1'b1, 1'b1, 1'b0, 32'h0);  chk_req("co3", 1'b1, 32'h40);
        chk("co3.valid", 32'(bus.instr_valid), 32'd0);
        chk("co3.fetch_count", bus.fetch_count, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);  chk_head("co4", 32'h40);

        // PC wrap, then reset in the middle of a drain.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE); chk_req("wr1", 1'b1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);         chk_req("wr2", 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b1, 32'h80);        chk_req("wr3", 1'b1, 32'h0);
        chk_head("wr3", 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, 32'h0);         chk_req("wr4", 1'b1, 32'h0);
        reset = 1'b1;
        #1;
        chk_req("wrrst", 1'b0, 32'h0);
        chk("wrrst.valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0);         chk_req("wr5", 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);         chk_req("wr6", 1'b1, 32'h0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            model_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                        $urandom_range(0, 99) < 6, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
